// File: rtl/pmips_pkg.sv
// Shared definitions for the PMIPS hazard detection and operand forwarding logic.
package pmips_pkg;

   // Forwarding select encoding; code 3 is unused and behaves as FWD_REG.
   localparam logic [1:0] FWD_REG   = 2'd0;
   localparam logic [1:0] FWD_EXMEM = 2'd1;
   localparam logic [1:0] FWD_MEMWB = 2'd2;

   // Bit positions inside the flush vector.
   localparam int unsigned FLUSH_IFID  = 0;
   localparam int unsigned FLUSH_IDEX  = 1;
   localparam int unsigned FLUSH_EXMEM = 2;

   // Tag rd field is sized for the widest supported register file (REG_AW <= 8).
   localparam int unsigned TAG_RD_W = 8;

   // Destination tag of the instruction held in ID/EX.
   typedef struct packed {
      logic                valid;
      logic                wen;
      logic                is_load;
      logic [TAG_RD_W-1:0] rd;
   } tag_t;

   // Destination tag once past EX: only "writes rd" still matters, since a load
   // in EX/MEM forwards from MEM/WB like any other producer.
   typedef struct packed {
      logic                wr;
      logic [TAG_RD_W-1:0] rd;
   } wtag_t;

endpackage

// File: rtl/pmips_fwd_mux.sv
// 3:1 operand mux selecting register-file, EX/MEM or MEM/WB data.
module pmips_fwd_mux import pmips_pkg::*; #(
   parameter int unsigned DATA_W = 16
) (
   input  logic [1:0]        sel_i,
   input  logic [DATA_W-1:0] reg_i,
   input  logic [DATA_W-1:0] exmem_i,
   input  logic [DATA_W-1:0] memwb_i,
   output logic [DATA_W-1:0] op_o
);

   // Pick the operand source; the illegal code falls back to the register file.
   always_comb begin
      op_o = reg_i;
      case (sel_i)
         FWD_EXMEM: op_o = exmem_i;
         FWD_MEMWB: op_o = memwb_i;
         default:   op_o = reg_i;
      endcase
   end

endmodule

// File: rtl/pmips_hazard_unit.sv
// Hazard and forwarding unit for the PMIPS 5-stage pipeline. Tracks destination
// tags of in-flight instructions, raises load-use stalls and branch flushes, and
// registers forwarding selects that steer the EX-stage operand muxes.
module pmips_hazard_unit import pmips_pkg::*; #(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned REG_AW   = 3,
   parameter int unsigned ZERO_REG = 1,
   parameter int unsigned CNT_W    = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic              id_rs1_used,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_rs2_used,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_rd_wen,
   input  logic              id_is_load,
   input  logic              br_taken,
   input  logic [DATA_W-1:0] ex_rdata1,
   input  logic [DATA_W-1:0] ex_rdata2,
   input  logic [DATA_W-1:0] exmem_alu,
   input  logic [DATA_W-1:0] memwb_wdata,
   input  logic              cnt_clr,
   output logic              stall,
   output logic [2:0]        flush,
   output logic [DATA_W-1:0] ex_opa,
   output logic [DATA_W-1:0] ex_opb,
   output logic [1:0]        fwd_sel_a,
   output logic [1:0]        fwd_sel_b,
   output logic [CNT_W-1:0]  stall_cnt
);

   // The MEM/WB tag is never stored: the regfile writes on the negative edge, so
   // a producer in MEM/WB is already visible to ID and never needs a forward.
   tag_t             issue_tag, tag0_d, tag0_q;
   wtag_t            tag1_d, tag1_q;
   logic [1:0]       sel_a_d, sel_a_q, sel_b_d, sel_b_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic             hit0_a, hit0_b, hit1_a, hit1_b;
   logic             hazard, stall_int, br_int;

   // Source register matches a pending write; r0 is ignored when hardwired.
   function automatic logic dest_hit(input logic [REG_AW-1:0]   src,
                                     input logic                used,
                                     input logic                wr,
                                     input logic [TAG_RD_W-1:0] rd);
      return used & wr & (rd == TAG_RD_W'(src)) & ~((ZERO_REG != 0) & (src == '0));
   endfunction

   // Younger producer wins; a load one ahead cannot forward (it stalls instead).
   function automatic logic [1:0] fwd_pick(input logic hit0, input logic load0,
                                           input logic hit1);
      if (hit0 && !load0) return FWD_EXMEM;
      if (hit1)           return FWD_MEMWB;
      return FWD_REG;
   endfunction

   // Hazard detection and stall/flush generation, gated while reset is low.
   always_comb begin
      hit0_a    = dest_hit(id_rs1, id_rs1_used, tag0_q.valid & tag0_q.wen, tag0_q.rd);
      hit0_b    = dest_hit(id_rs2, id_rs2_used, tag0_q.valid & tag0_q.wen, tag0_q.rd);
      hit1_a    = dest_hit(id_rs1, id_rs1_used, tag1_q.wr, tag1_q.rd);
      hit1_b    = dest_hit(id_rs2, id_rs2_used, tag1_q.wr, tag1_q.rd);
      hazard    = id_valid & tag0_q.is_load & (hit0_a | hit0_b);
      br_int    = br_taken & reset;
      stall_int = hazard & ~br_taken & reset;
      stall     = stall_int;
      flush              = 3'b000;
      flush[FLUSH_IFID]  = br_int;
      flush[FLUSH_IDEX]  = br_int;
      flush[FLUSH_EXMEM] = br_int;
   end

   // Next-state for tag pipeline, forwarding selects and stall counter.
   always_comb begin
      issue_tag.valid   = id_valid;
      issue_tag.wen     = id_rd_wen;
      issue_tag.is_load = id_is_load;
      issue_tag.rd      = TAG_RD_W'(id_rd);

      tag0_d    = issue_tag;
      tag1_d.wr = tag0_q.valid & tag0_q.wen;
      tag1_d.rd = tag0_q.rd;
      sel_a_d   = fwd_pick(hit0_a, tag0_q.is_load, hit1_a);
      sel_b_d   = fwd_pick(hit0_b, tag0_q.is_load, hit1_b);

      if (br_taken) begin
         // The ID and EX instructions are squashed along with their tags.
         tag0_d  = '0;
         tag1_d  = '0;
         sel_a_d = FWD_REG;
         sel_b_d = FWD_REG;
      end else if (stall_int) begin
         tag0_d  = '0;
         sel_a_d = FWD_REG;
         sel_b_d = FWD_REG;
      end

      cnt_d = cnt_q;
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (stall_int && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // State registers with asynchronous active-low reset to an empty pipeline.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tag0_q  <= '0;
         tag1_q  <= '0;
         sel_a_q <= FWD_REG;
         sel_b_q <= FWD_REG;
         cnt_q   <= '0;
      end else begin
         tag0_q  <= tag0_d;
         tag1_q  <= tag1_d;
         sel_a_q <= sel_a_d;
         sel_b_q <= sel_b_d;
         cnt_q   <= cnt_d;
      end
   end

   assign fwd_sel_a = sel_a_q;
   assign fwd_sel_b = sel_b_q;
   assign stall_cnt = cnt_q;

   pmips_fwd_mux #(
      .DATA_W(DATA_W)
   ) u_mux_a (
      .sel_i  (sel_a_q),
      .reg_i  (ex_rdata1),
      .exmem_i(exmem_alu),
      .memwb_i(memwb_wdata),
      .op_o   (ex_opa)
   );

   pmips_fwd_mux #(
      .DATA_W(DATA_W)
   ) u_mux_b (
      .sel_i  (sel_b_q),
      .reg_i  (ex_rdata2),
      .exmem_i(exmem_alu),
      .memwb_i(memwb_wdata),
      .op_o   (ex_opb)
   );

endmodule

// File: doc/pmips_hazard_unit.md
Name:
pmips_hazard_unit

Overview:
- Parametrised hazard and forwarding unit for the next-generation PMIPS 5-stage pipeline (IF, ID, EX, MEM, WB).
- Replaces instruction-comparison hazard logic inside the controller with an internal destination-tag pipeline.
- Generates PC/IF-ID stall, branch flushes and registered forwarding selects, and contains the EX-stage operand forwarding muxes.
- Branches resolve in MEM, and the register file writes on the negative clock edge, as in the current core.

Parameters:
- DATA_W, 16: operand/result width of forwarding muxes.
- REG_AW, 3: register address width (2**REG_AW registers).
- ZERO_REG, 1: when 1, register 0 never creates a hazard or forward.
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  IF/ID holds a real instruction.
- id_rs1  in  REG_AW  ID source register 1 (read address 1).
- id_rs1_used  in  1  instruction reads rs1.
- id_rs2  in  REG_AW  ID source register 2.
- id_rs2_used  in  1  instruction reads rs2.
- id_rd  in  REG_AW  final destination after RegDst selection.
- id_rd_wen  in  1  instruction writes a register.
- id_is_load  in  1  instruction is a load (MemtoReg).
- br_taken  in  1  branch in EX/MEM taken (Branch & ALUZero).
- ex_rdata1  in  DATA_W  ID/EX RegRead1.
- ex_rdata2  in  DATA_W  ID/EX RegRead2.
- exmem_alu  in  DATA_W  EX/MEM ALU result.
- memwb_wdata  in  DATA_W  write-back mux output.
- cnt_clr  in  1  synchronous clear of stall_cnt.
- stall  out  1  hold PC and IF/ID; load a bubble into ID/EX.
- flush  out  3  bit0 IF/ID, bit1 ID/EX, bit2 EX/MEM; load a bubble.
- ex_opa  out  DATA_W  forwarded ALU operand A.
- ex_opb  out  DATA_W  forwarded register operand B, before the ALUSrc mux.
- fwd_sel_a  out  2  0 regfile, 1 EX/MEM, 2 MEM/WB (debug).
- fwd_sel_b  out  2  same encoding for operand B.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Tag pipeline: tag[k] = {valid, wen, is_load, rd}.
  - tag[0] mirrors ID/EX, tag[1] mirrors EX/MEM, tag[2] mirrors MEM/WB.
  - Every cycle: tag[2] <= tag[1]; tag[1] <= tag[0]; tag[0] <= issue tag.
  - Issue tag = {id_valid, id_rd_wen, id_is_load, id_rd}.
- Match(s, k): all of the following are true:
  - source s is used;
  - tag[k].valid and tag[k].wen;
  - tag[k].rd == s;
  - not (ZERO_REG and s == 0).
- Load-use hazard: id_valid and Match(rs1 or rs2, 0) with tag[0].is_load.
- Stall and flush:
  - stall = hazard & ~br_taken.
  - flush = {3{br_taken}}; flush overrides stall.
- On stall:
  - tag[0] <= 0 (bubble); internal select registers <= 0.
  - tag[1] and tag[2] still advance.
  - Exactly one stall cycle per load-use pair.
- On br_taken:
  - next tag[0] <= 0 and next tag[1] <= 0 (younger EX and ID instructions squashed).
  - tag[2] <= tag[1] (the branch itself).
- Forward select for each source, computed in ID, registered into sel_a/sel_b:
  - Match(s, 0) and not load -> 1.
  - Else Match(s, 1) -> 2.
  - Else -> 0.
  - tag[0] takes priority over tag[1].
  - A match on tag[2] needs no forward, because the negedge regfile write is visible in ID.
- EX muxes (combinational from sel registers):
  - ex_opa = sel_a==1 ? exmem_alu : sel_a==2 ? memwb_wdata : ex_rdata1.
  - ex_opb is the same, using ex_rdata2.
  - Encoding 3 is illegal; treat it as 0.
- stall_cnt: increments when stall=1 and saturates at all ones; cnt_clr has priority over increment.
- Reset (reset==0, asynchronous):
  - all tags, sel registers and stall_cnt go to 0.
  - stall=0, flush=0 (outputs gated while reset is low).
  - ex_opa = ex_rdata1 and ex_opb = ex_rdata2.
- Reset released mid-stream: the first cycle after release behaves as an empty pipeline, so there are no spurious forwards.

Decomposition:
- Shared package pmips_pkg holds:
  - FWD_REG=0, FWD_EXMEM=1, FWD_MEMWB=2;
  - tag struct typedef {valid, wen, is_load, rd};
  - flush bit indices.
- One natural sub-module: pmips_fwd_mux (3:1 DATA_W operand mux driven by a 2-bit select), instantiated twice.

Test Plan:
- ALU dependency distance 1: issue r3=r1+r2, then r4=r3+r1; exmem_alu=0x0042 -> fwd_sel_a=1, ex_opa=0x0042, no stall.
- Distance 2: r3 producer, independent op, then r5=r3+r3; memwb_wdata=0x1234 -> fwd_sel_a=fwd_sel_b=2, both operands 0x1234.
- Load-use: load r2 then add r6=r2+r1 -> stall=1 for exactly 1 cycle; next EX cycle fwd_sel_a=2 with memwb_wdata=load data 0xBEEF; stall_cnt=1.
- Taken branch during a load-use hazard: br_taken=1 in the same cycle as the hazard -> stall=0, flush=3'b111; the next two cycles show no forwards from squashed tags.
- Register 0: producer writes r0, consumer reads r0 with ZERO_REG=1 -> fwd_sel=0, no stall; with ZERO_REG=0 -> fwd_sel=1.
- Reset and counter: drive 70000 stalls with CNT_W=16 -> stall_cnt holds 0xFFFF; assert reset low mid-stall -> stall=0 and stall_cnt=0 immediately, without waiting for a clock edge.
